mmss_display_scan: RTL and testbench

- Consumer end of the time-core BCD digit bus. Takes the four mm:ss BCD digits and adjust-mode status, and drives a 4-digit multiplexed common-anode 7-segment display.
- Snapshots the digits once per scan frame, so no frame ever shows a mix of old and new values.
- Blinks the field being adjusted and lights the decimal point of the minutes-ones digit as the mm.ss separator.
- Sits between the time core and the board display pins.

---
 rtl/mmss_display_scan.sv | 155 +++++++++++++++
 tb/tb_mmss_display_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mmss_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mmss_display_scan
//  Description : Multiplexed 4-digit 7-segment driver for an mm:ss time core.
//                Latches the BCD digits once per scan frame (tear-free),
//                blinks the field under adjustment and lights the decimal
//                point of the minutes-ones digit as the mm.ss separator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmss_display_scan #(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       adjust_mode,
    input  logic       sel_minutes,
    input  logic       sel_seconds,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);

    // Polarity mask: XOR-ing an active-high pattern with this gives pin levels.
    localparam logic c_POL = (SEG_ACTIVE_LOW != 0);

    logic [c_REF_W-1:0] r_ref_cnt;
    logic [1:0]         r_idx;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [3:0][3:0]    r_shadow;
    logic               r_frame_tick;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_ref_last;
    logic               w_wrap;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg_hi;
    logic               w_in_field;
    logic               w_blank;
    logic [3:0]         w_an_hi;
    logic               w_dp_hi;

    assign w_ref_last = (r_ref_cnt == c_REF_LAST);
    assign w_wrap     = w_ref_last && (r_idx == 2'd3);
    assign w_digit    = r_shadow[r_idx];

    // Refresh counter and digit index; digit advances on refresh terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (w_ref_last) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + c_REF_W'(1);
        end
    end

    // Shadow digits are refreshed only at the frame wrap so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_wrap;
            if (w_wrap) begin
                r_shadow[0] <= sec_ones;
                r_shadow[1] <= sec_tens;
                r_shadow[2] <= min_ones;
                r_shadow[3] <= min_tens;
            end
        end
    end

    // Blink timebase: parked in the visible phase outside adjust mode.
    always_ff @(posedge clk) begin
        if (rst || !adjust_mode) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == c_BLK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + c_BLK_W'(1);
        end
    end

    // BCD to active-high segment pattern {g,f,e,d,c,b,a}; non-BCD shows a dash.
    always_comb begin
        w_seg_hi = 7'h40;
        case (w_digit)
            4'd0: w_seg_hi = 7'h3F;
            4'd1: w_seg_hi = 7'h06;
            4'd2: w_seg_hi = 7'h5B;
            4'd3: w_seg_hi = 7'h4F;
            4'd4: w_seg_hi = 7'h66;
            4'd5: w_seg_hi = 7'h6D;
            4'd6: w_seg_hi = 7'h7D;
            4'd7: w_seg_hi = 7'h07;
            4'd8: w_seg_hi = 7'h7F;
            4'd9: w_seg_hi = 7'h6F;
            default: w_seg_hi = 7'h40;
        endcase
    end

    // Field membership of the current slot; seconds selection wins over minutes.
    always_comb begin
        w_in_field = 1'b0;
        if (sel_seconds) begin
            w_in_field = (r_idx <= 2'd1);
        end else if (sel_minutes) begin
            w_in_field = (r_idx >= 2'd2);
        end
    end

    assign w_blank = adjust_mode && !r_blink_phase && w_in_field;
    assign w_an_hi = w_blank ? 4'b0000 : (4'b0001 << r_idx);
    assign w_dp_hi = (r_idx == 2'd2);

    // Pin registers: one cycle behind the index, polarity applied here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= {4{c_POL}};
            r_seg <= {7{c_POL}};
            r_dp  <= c_POL;
        end else begin
            r_an  <= w_an_hi ^ {4{c_POL}};
            r_seg <= w_seg_hi ^ {7{c_POL}};
            r_dp  <= w_dp_hi ^ c_POL;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_mmss_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmss_display_scan
//  Description : Directed self-checking bench for mmss_display_scan with
//                REFRESH_DIV=4, BLINK_DIV=8, active-low outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmss_display_scan;

    logic       clk;
    logic       rst;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       adjust_mode;
    logic       sel_minutes;
    logic       sel_seconds;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    mmss_display_scan #(
        .REFRESH_DIV   (4),
        .BLINK_DIV     (8),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .adjust_mode(adjust_mode),
        .sel_minutes(sel_minutes),
        .sel_seconds(sel_seconds),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame vectors: inputs mm:ss and expected active-low seg for slots 0..3.
    typedef struct {
        logic [3:0] mt, mo, st, so;
        logic [6:0] e0, e1, e2, e3;
        string      name;
    } vec_t;

    vec_t       vecs [4];
    logic [6:0] exp_seg [4];
    logic [3:0] an_on [4];

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got an/seg/dp/ft=%b_%h_%b_%b expected %b_%h_%b_%b",
                     name, act[12:9], act[8:2], act[1], act[0],
                     exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    // Check the four cycles of one digit slot starting at the next negedge.
    task automatic check_slot(input int slot, input bit blank, input string tag);
        logic [3:0] ean;
        logic       edp;
        logic       eft;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ean = blank ? 4'b1111 : an_on[slot];
            edp = (slot == 2) ? 1'b0 : 1'b1;
            eft = (slot == 3) && (c == 3);
            chk($sformatf("%s slot%0d cyc%0d", tag, slot, c),
                {an, seg, dp, frame_tick}, {ean, exp_seg[slot], edp, eft});
        end
    endtask

    task automatic check_frame(input bit b0, input bit b1, input bit b2, input bit b3,
                               input string tag);
        check_slot(0, b0, tag);
        check_slot(1, b1, tag);
        check_slot(2, b2, tag);
        check_slot(3, b3, tag);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 64);
        if (frame_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_tick timeout got %b expected 1", tag, frame_tick);
        end
    endtask

    task automatic set_digits(input logic [3:0] mt, input logic [3:0] mo,
                              input logic [3:0] st, input logic [3:0] so);
        min_tens = mt;
        min_ones = mo;
        sec_tens = st;
        sec_ones = so;
    endtask

    task automatic set_exp(input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
        exp_seg[0] = e0;
        exp_seg[1] = e1;
        exp_seg[2] = e2;
        exp_seg[3] = e3;
    endtask

    initial begin
        an_on[0] = 4'b1110;
        an_on[1] = 4'b1101;
        an_on[2] = 4'b1011;
        an_on[3] = 4'b0111;

        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 7'h19, 7'h30, 7'h24, 7'h79, "12:34"};
        vecs[1] = '{4'd5, 4'd6, 4'd0, 4'd7, 7'h78, 7'h40, 7'h02, 7'h12, "56:07"};
        vecs[2] = '{4'd8, 4'd9, 4'd5, 4'hC, 7'h3F, 7'h12, 7'h10, 7'h00, "89:5C"};
        vecs[3] = '{4'hF, 4'd0, 4'd9, 4'hA, 7'h3F, 7'h10, 7'h40, 7'h3F, "F0:9A"};

        // Reset held three cycles: everything inactive.
        rst = 1'b1;
        adjust_mode = 1'b0;
        sel_minutes = 1'b0;
        sel_seconds = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset cyc%0d", i), {an, seg, dp, frame_tick},
                {4'b1111, 7'h7F, 1'b1, 1'b0});
        end

        // First frame after reset shows zeros even though 12:34 is applied.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        rst = 1'b0;
        set_exp(7'h40, 7'h40, 7'h40, 7'h40);
        check_frame(0, 0, 0, 0, "first frame");
        set_exp(7'h19, 7'h30, 7'h24, 7'h79);
        check_frame(0, 0, 0, 0, "12:34 frame");

        // Table-driven frames, including non-BCD codes.
        foreach (vecs[i]) begin
            set_digits(vecs[i].mt, vecs[i].mo, vecs[i].st, vecs[i].so);
            wait_frame(vecs[i].name);
            set_exp(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
            check_frame(0, 0, 0, 0, vecs[i].name);
        end

        // No tearing: change to 56:07 while digit 1 is being scanned.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        wait_frame("tear setup");
        set_exp(7'h19, 7'h30, 7'h24, 7'h79);
        check_slot(0, 0, "tear old");
        set_digits(4'd5, 4'd6, 4'd0, 4'd7);
        check_slot(1, 0, "tear old");
        check_slot(2, 0, "tear old");
        check_slot(3, 0, "tear old");
        set_exp(7'h78, 7'h40, 7'h02, 7'h12);
        check_frame(0, 0, 0, 0, "tear new");

        // Seconds blink, enabled half a frame in so blank phase lands on slots 0,1.
        check_slot(0, 0, "blink pre");
        check_slot(1, 0, "blink pre");
        adjust_mode = 1'b1;
        sel_seconds = 1'b1;
        check_slot(2, 0, "blink sec");
        check_slot(3, 0, "blink sec");
        check_frame(1, 1, 0, 0, "blink sec");
        sel_minutes = 1'b1;
        check_frame(1, 1, 0, 0, "blink both");
        adjust_mode = 1'b0;
        check_frame(0, 0, 0, 0, "adjust off");

        // Minutes-only blink from a frame start: slots 2,3 fall in the blank phase.
        adjust_mode = 1'b1;
        sel_seconds = 1'b0;
        check_slot(0, 0, "blink min");
        check_slot(1, 0, "blink min");
        @(negedge clk);
        chk("blink min slot2 blank", {an, seg, dp, frame_tick},
            {4'b1111, 7'h02, 1'b0, 1'b0});

        // Reset while digit 2 is blanked: immediate return to reset values.
        rst = 1'b1;
        @(negedge clk);
        chk("mid-frame reset", {an, seg, dp, frame_tick},
            {4'b1111, 7'h7F, 1'b1, 1'b0});
        rst = 1'b0;
        set_exp(7'h40, 7'h40, 7'h40, 7'h40);
        check_frame(0, 0, 1, 1, "post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
